// File: rtl/syn_fifo_ctl.sv
// syn_fifo_ctl: single-clock FIFO with registered or show-ahead read,
// programmable almost-full/empty thresholds, fill level and sticky errors.
// Ports:
//   clk, rst_n (sync, active-low), flush (sync clear)
//   wr, wdata -> write side; full, afull status
//   rd -> read request / head acknowledge; rdata, rvalid read side
//   empty, aempty, level (0..D), ovf, udf (sticky until flush/reset)
module syn_fifo_ctl #(
    parameter int p_nbit_d    = 8,
    parameter int p_nbit_a    = 4,
    parameter int p_showahead = 0,
    parameter int p_afull_th  = 12,
    parameter int p_aempty_th = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                wr,
    input  logic [p_nbit_d-1:0] wdata,
    output logic                full,
    output logic                afull,
    input  logic                rd,
    output logic [p_nbit_d-1:0] rdata,
    output logic                rvalid,
    output logic                empty,
    output logic                aempty,
    output logic [p_nbit_a:0]   level,
    output logic                ovf,
    output logic                udf
);

    localparam logic [p_nbit_a:0] DEPTH     = {1'b1, {p_nbit_a{1'b0}}};
    localparam logic [p_nbit_a:0] AFULL_TH  = p_afull_th[p_nbit_a:0];
    localparam logic [p_nbit_a:0] AEMPTY_TH = p_aempty_th[p_nbit_a:0];

    logic [p_nbit_d-1:0] mem [0:(1<<p_nbit_a)-1];

    logic [p_nbit_a:0]   wptr;
    logic [p_nbit_a:0]   rptr;
    logic [p_nbit_a:0]   level_next;
    logic [p_nbit_a-1:0] waddr;
    logic [p_nbit_a-1:0] raddr;
    logic                rd_ok;
    logic                wr_ok;

    assign waddr = wptr[p_nbit_a-1:0];
    assign raddr = rptr[p_nbit_a-1:0];

    // A read frees a slot in the same cycle, so a full FIFO still
    // accepts a write when it is also being read.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        level_next = level;
        if (wr_ok && !rd_ok) begin
            level_next = level + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            level  <= level_next;
            full   <= (level_next == DEPTH);
            afull  <= (level_next >= AFULL_TH);
            empty  <= (level_next == '0);
            aempty <= (level_next <= AEMPTY_TH);
            if (wr && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage is not cleared; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    if (p_showahead != 0) begin : g_showahead
        assign rdata  = mem[raddr];
        assign rvalid = ~empty;
    end else begin : g_registered
        logic [p_nbit_d-1:0] rdata_q;
        logic                rvalid_q;

        // On flush the last word stays on rdata; only rvalid drops.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (flush) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok) begin
                    rdata_q <= mem[raddr];
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_syn_fifo_ctl.sv
// tb_syn_fifo_ctl: directed bench for syn_fifo_ctl, one registered-read
// instance and one show-ahead instance driven by the same stimulus.
module tb_syn_fifo_ctl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;

    logic       full0, afull0, empty0, aempty0, rvalid0, ovf0, udf0;
    logic [7:0] rdata0;
    logic [4:0] level0;

    logic       full1, afull1, empty1, aempty1, rvalid1, ovf1, udf1;
    logic [7:0] rdata1;
    logic [4:0] level1;

    int total = 0;
    int bad   = 0;

    syn_fifo_ctl #(.p_showahead(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr(wr), .wdata(wdata), .full(full0), .afull(afull0),
        .rd(rd), .rdata(rdata0), .rvalid(rvalid0),
        .empty(empty0), .aempty(aempty0), .level(level0),
        .ovf(ovf0), .udf(udf0)
    );

    syn_fifo_ctl #(.p_showahead(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr(wr), .wdata(wdata), .full(full1), .afull(afull1),
        .rd(rd), .rdata(rdata1), .rvalid(rvalid1),
        .empty(empty1), .aempty(aempty1), .level(level1),
        .ovf(ovf1), .udf(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        wdata = 8'h00;
        tick();
        tick();

        chk("rst_level",  int'(level0),  0);
        chk("rst_empty",  int'(empty0),  1);
        chk("rst_aempty", int'(aempty0), 1);
        chk("rst_full",   int'(full0),   0);
        chk("rst_afull",  int'(afull0),  0);
        chk("rst_ovf",    int'(ovf0),    0);
        chk("rst_udf",    int'(udf0),    0);
        chk("rst_rvalid", int'(rvalid0), 0);
        chk("rst_rdata",  int'(rdata0),  0);
        chk("rst_rvalid1", int'(rvalid1), 0);
        rst_n = 1'b1;
        tick();

        // fill 0x00..0x0F, check flags at each level
        for (int i = 0; i < 16; i++) begin
            wr    = 1'b1;
            wdata = 8'(i);
            tick();
            chk("fill_level",  int'(level0),  i + 1);
            chk("fill_afull",  int'(afull0),  int'(i + 1 >= 12));
            chk("fill_aempty", int'(aempty0), int'(i + 1 <= 2));
            chk("fill_full",   int'(full0),   int'(i == 15));
            chk("fill_empty",  int'(empty0),  0);
        end
        wr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            tick();
            chk("drain_rvalid", int'(rvalid0), 1);
            chk("drain_rdata",  int'(rdata0),  i);
            chk("drain_level",  int'(level0),  15 - i);
            chk("drain_empty",  int'(empty0),  int'(i == 15));
            chk("drain_aempty", int'(aempty0), int'(15 - i <= 2));
        end
        rd = 1'b0;
        tick();
        chk("idle_rvalid", int'(rvalid0), 0);
        chk("idle_rdata",  int'(rdata0),  8'h0F);

        // overflow at full; 0xAA must be dropped
        for (int i = 0; i < 16; i++) begin
            wr    = 1'b1;
            wdata = 8'(8'h10 + i);
            tick();
        end
        wdata = 8'hAA;
        tick();
        chk("ovf_level", int'(level0), 16);
        chk("ovf_flag",  int'(ovf0),   1);
        chk("ovf_full",  int'(full0),  1);
        wr = 1'b0;
        tick();
        chk("ovf_sticky", int'(ovf0), 1);
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            tick();
            chk("ovf_drain", int'(rdata0), 8'h10 + i);
        end
        rd = 1'b0;
        tick();
        chk("ovf_empty", int'(empty0), 1);
        chk("ovf_hold",  int'(ovf0),   1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ovf_flushed", int'(ovf0), 0);

        // simultaneous read/write at full across pointer wrap
        for (int i = 0; i < 16; i++) begin
            wr    = 1'b1;
            wdata = 8'(i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            wr    = 1'b1;
            rd    = 1'b1;
            wdata = 8'(16 + k);
            tick();
            chk("rw_level", int'(level0), 16);
            chk("rw_rdata", int'(rdata0), k);
            chk("rw_ovf",   int'(ovf0),   0);
        end
        wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            tick();
            chk("rw_drain", int'(rdata0), 20 + i);
        end
        rd = 1'b0;
        tick();
        chk("rw_empty", int'(empty0), 1);

        // underflow with simultaneous write into empty FIFO
        rd    = 1'b1;
        wr    = 1'b1;
        wdata = 8'h55;
        tick();
        chk("udf_flag",   int'(udf0),    1);
        chk("udf_level",  int'(level0),  1);
        chk("udf_rvalid", int'(rvalid0), 0);
        wr = 1'b0;
        tick();
        chk("udf_rdata",  int'(rdata0),  8'h55);
        chk("udf_rvalid2", int'(rvalid0), 1);
        chk("udf_level0", int'(level0),  0);
        rd = 1'b0;
        tick();
        chk("udf_sticky", int'(udf0), 1);

        // flush beats concurrent wr/rd
        for (int i = 0; i < 5; i++) begin
            wr    = 1'b1;
            wdata = 8'(8'h60 + i);
            tick();
        end
        chk("pre_flush_level", int'(level0), 5);
        flush = 1'b1;
        wr    = 1'b1;
        rd    = 1'b1;
        wdata = 8'h99;
        tick();
        flush = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        chk("fl_level",  int'(level0),  0);
        chk("fl_empty",  int'(empty0),  1);
        chk("fl_ovf",    int'(ovf0),    0);
        chk("fl_udf",    int'(udf0),    0);
        chk("fl_rvalid", int'(rvalid0), 0);
        chk("fl_rdata",  int'(rdata0),  8'h55);
        wr    = 1'b1;
        wdata = 8'h77;
        tick();
        wdata = 8'h78;
        tick();
        wr = 1'b0;
        rd = 1'b1;
        tick();
        chk("fl_rd0", int'(rdata0), 8'h77);
        tick();
        chk("fl_rd1", int'(rdata0), 8'h78);
        rd = 1'b0;
        tick();
        chk("fl_end_empty", int'(empty0), 1);

        // show-ahead instance
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sa_idle_rvalid", int'(rvalid1), 0);
        wr    = 1'b1;
        wdata = 8'h11;
        tick();
        wr = 1'b0;
        chk("sa_rvalid", int'(rvalid1), 1);
        chk("sa_rdata",  int'(rdata1),  8'h11);
        tick();
        chk("sa_hold",   int'(rdata1),  8'h11);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("sa_consumed", int'(rvalid1), 0);
        wr    = 1'b1;
        rd    = 1'b1;
        wdata = 8'h22;
        tick();
        chk("sa_b2b0_v", int'(rvalid1), 1);
        chk("sa_b2b0_d", int'(rdata1),  8'h22);
        wdata = 8'h33;
        tick();
        chk("sa_b2b1_v", int'(rvalid1), 1);
        chk("sa_b2b1_d", int'(rdata1),  8'h33);
        chk("sa_level",  int'(level1),  1);
        wr = 1'b0;
        tick();
        rd = 1'b0;
        chk("sa_final", int'(rvalid1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
